// File: rtl/alu_pkg.sv
// Shared ALU definitions: command codes, divider width and divider FSM states.
package alu_pkg;

   localparam int DIV_W = 4;

   localparam logic [2:0] CMD_ADD = 3'd1;
   localparam logic [2:0] CMD_SUB = 3'd2;
   localparam logic [2:0] CMD_MUL = 3'd3;
   localparam logic [2:0] CMD_DIV = 3'd4;
   localparam logic [2:0] CMD_MOD = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_div_mod_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] pr_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] pr_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] pr_shift;
   logic [WIDTH:0] diff;

   assign pr_shift = {pr_i, bit_i};
   assign diff     = pr_shift - {1'b0, divisor_i};

   // A clear MSB means the trial subtraction did not borrow, so the divisor fits.
   assign q_bit_o  = ~diff[WIDTH];
   assign pr_o     = diff[WIDTH] ? pr_shift[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/seq_div_mod.sv
// Sequential unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_div_mod
   import alu_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   div_state_t       state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] pr_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             done_q;
   logic             div_zero_q;

   logic [WIDTH-1:0] pr_d;
   logic             q_bit;
   logic [WIDTH-1:0] q_d;

   div_step #(.WIDTH(WIDTH)) u_step (
      .pr_i      (pr_q),
      .bit_i     (dvd_q[count_q]),
      .divisor_i (dvs_q),
      .pr_o      (pr_d),
      .q_bit_o   (q_bit)
   );

   always_comb begin
      q_d          = q_q;
      q_d[count_q] = q_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         pr_q        <= '0;
         q_q         <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  if (divisor != '0) begin
                     dvd_q      <= dividend;
                     dvs_q      <= divisor;
                     pr_q       <= '0;
                     q_q        <= '0;
                     count_q    <= CW'(WIDTH - 1);
                     div_zero_q <= 1'b0;
                     state_q    <= RUN;
                  end else begin
                     // Divide-by-zero short-circuits straight to DONE with all-ones quotient.
                     quotient_q  <= '1;
                     remainder_q <= dividend;
                     div_zero_q  <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            RUN: begin
               pr_q <= pr_d;
               q_q  <= q_d;
               if (count_q == '0) begin
                  quotient_q  <= q_d;
                  remainder_q <= pr_d;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  count_q <= count_q - CW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div_mod.sv
// Directed bench for seq_div_mod: handshake timing, held start, divide-by-zero, abort and full sweep.
module tb_seq_div_mod;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [3:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

   int tests;
   int fails;

   seq_div_mod #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE and check latency, busy length and results.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int exp_lat,
                         input logic [3:0] eq, input logic [3:0] er, input logic ez,
                         input string tag);
      int n;
      int nb;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start = 1'b0;
      n  = 0;
      nb = 0;
      while (!done && n < 20) begin
         if (busy) nb++;
         tick();
         n++;
      end
      if (busy) nb++;
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_q"}, quotient, eq);
      chk({tag, "_r"}, remainder, er);
      chk({tag, "_z"}, div_zero, ez);
      tick();
      chk({tag, "_busylen"}, nb, exp_lat + 1);
      chk({tag, "_idle"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int n;
      int dones;
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      // Reset state
      repeat (2) tick();
      chk("rst_outs", {busy, done, quotient, remainder, div_zero}, 11'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_idle", {busy, done}, 2'b00);

      // Basic operation and timing
      run_op(4'd6, 4'd1, 4, 4'd6, 4'd0, 1'b0, "div6_1");

      // Held start: 13/4, 15/15, 3/5 issued every 6 cycles
      dividend = 4'd13;
      divisor  = 4'd4;
      start    = 1'b1;
      tick();
      n = 1;
      while (!done && n < 20) begin tick(); n++; end
      chk("held1_q", quotient, 4'd3);
      chk("held1_r", remainder, 4'd1);
      dividend = 4'd15;
      divisor  = 4'd15;
      tick();
      n = 1;
      while (!done && n < 20) begin
         if (n == 3) chk("held2_hold_q", quotient, 4'd3);
         tick();
         n++;
      end
      chk("held2_interval", n, 6);
      chk("held2_q", quotient, 4'd1);
      chk("held2_r", remainder, 4'd0);
      dividend = 4'd3;
      divisor  = 4'd5;
      tick();
      n = 1;
      while (!done && n < 20) begin tick(); n++; end
      start = 1'b0;
      chk("held3_interval", n, 6);
      chk("held3_q", quotient, 4'd0);
      chk("held3_r", remainder, 4'd3);
      repeat (2) tick();

      // Divide by zero, then a normal op clears the flag
      run_op(4'd7, 4'd0, 0, 4'd15, 4'd7, 1'b1, "div7_0");
      run_op(4'd8, 4'd2, 4, 4'd4, 4'd0, 1'b0, "div8_2");

      // Start pulsed again during RUN with changed operands is ignored
      dividend = 4'd9;
      divisor  = 4'd2;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      dividend = 4'd1;
      divisor  = 4'd1;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = 4'd5;
      divisor  = 4'd7;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            dones++;
            chk("ign_q", quotient, 4'd4);
            chk("ign_r", remainder, 4'd1);
         end
         tick();
      end
      chk("ign_done_count", dones, 1);

      // Asynchronous reset mid-RUN
      dividend = 4'd14;
      divisor  = 4'd3;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_outs", {busy, done, quotient, remainder, div_zero}, 11'd0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) dones++;
      end
      chk("arst_quiet", dones, 0);

      // Exhaustive sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            logic [3:0] eq, er;
            logic       ez;
            dividend = a[3:0];
            divisor  = b[3:0];
            start    = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!done && n < 20) begin tick(); n++; end
            if (b == 0) begin
               eq = 4'd15;
               er = a[3:0];
               ez = 1'b1;
            end else begin
               eq = 4'(a / b);
               er = 4'(a % b);
               ez = 1'b0;
            end
            chk($sformatf("sweep_%0d_%0d", a, b), {done, div_zero, quotient, remainder},
                {1'b1, ez, eq, er});
            if (b != 0)
               chk($sformatf("inv_%0d_%0d", a, b),
                   ((int'(quotient) * b + int'(remainder)) == a) && (int'(remainder) < b), 1);
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
